// File: rtl/uart_pkg.sv
// Shared types, parity-mode constants and the parity helper for the
// parametrised UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } rx_state_e;

    localparam logic [1:0] PARITY_NONE = 2'd0;
    localparam logic [1:0] PARITY_ODD  = 2'd1;
    localparam logic [1:0] PARITY_EVEN = 2'd2;

    // Widest legal data word; narrower words are zero-extended, which
    // leaves their XOR unchanged.
    localparam int MAX_DATA_BITS = 9;

    // Expected parity bit on the line for a given data word and mode.
    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                        input logic [1:0]               mode);
        logic x;
        x = ^data;
        if (mode == PARITY_ODD) begin
            return ~x;
        end else begin
            return x;
        end
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Output FIFO of the UART receiver: circular buffer with registered storage,
// combinational head read and overrun detection on a full-without-pop push.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             overrun
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             pop_s, full_s, wr_s;

    assign pop_s   = valid_q & m_ready;
    assign full_s  = (count_q == FULL);
    assign m_data  = mem_q[rd_ptr_q];
    assign m_valid = valid_q;
    assign overrun = overrun_q;

    // Next-state for storage, pointers, occupancy and the overrun pulse.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        wr_s      = 1'b0;
        // A pop in the same cycle frees the slot a full FIFO would refuse.
        if (push && (!full_s || pop_s)) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
            wr_s            = 1'b1;
        end else begin
            wr_s = 1'b0;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        valid_d   = (count_d != '0);
        overrun_d = push & full_s & ~pop_s;
    end

    // FIFO state registers with synchronous flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q     <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver: 2-FF synchroniser, 3-sample
// majority voter, framing FSM and an output FIFO on a valid/ready stream.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] MID_M1 = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] MID    = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] MID_P1 = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] LAST   = TW'(OVERSAMPLE - 1);
    localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [1:0] PAR_MODE  = 2'(PARITY);

    logic                 sync1_q, sync2_q, rx_s;
    rx_state_e            state_q, state_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [3:0]           bit_idx_q, bit_idx_d;
    logic [1:0]           vote_q, vote_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_err_q, par_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 busy_q, busy_d;
    logic                 push_s, voted_s, dec_s, end_s;

    assign rx_s    = sync2_q;
    assign voted_s = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s) | (vote_q[1] & rx_s);
    assign dec_s   = (tick_cnt_q == MID_P1);
    assign end_s   = (tick_cnt_q == LAST);

    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign busy       = busy_q;

    // Two-flop synchroniser for the asynchronous serial line (idles high).
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
        end
    end

    // Framing FSM, tick counter and voter; everything advances on baud ticks.
    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        bit_idx_d    = bit_idx_q;
        vote_d       = vote_q;
        shift_d      = shift_q;
        par_err_d    = par_err_q;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        push_s       = 1'b0;
        if (baud_tick) begin
            if (state_q == S_IDLE || state_q == S_BREAK) begin
                tick_cnt_d = tick_cnt_q;
            end else if (end_s) begin
                tick_cnt_d = '0;
            end else begin
                tick_cnt_d = tick_cnt_q + TW'(1);
            end
            if (tick_cnt_q == MID_M1) begin
                vote_d = {vote_q[1], rx_s};
            end else if (tick_cnt_q == MID) begin
                vote_d = {rx_s, vote_q[0]};
            end else begin
                vote_d = vote_q;
            end
            case (state_q)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_d    = S_START;
                        tick_cnt_d = '0;
                        par_err_d  = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_START: begin
                    // A start edge that does not survive the vote is noise.
                    if (dec_s && voted_s) begin
                        state_d = S_IDLE;
                    end else if (end_s) begin
                        state_d   = S_DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d = S_START;
                    end
                end
                S_DATA: begin
                    if (dec_s) begin
                        shift_d = {voted_s, shift_q[DATA_BITS-1:1]};
                    end else begin
                        shift_d = shift_q;
                    end
                    if (end_s && bit_idx_q == DATA_LAST) begin
                        state_d   = (PAR_MODE != PARITY_NONE) ? S_PARITY : S_STOP;
                        bit_idx_d = '0;
                    end else if (end_s) begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end else begin
                        bit_idx_d = bit_idx_q;
                    end
                end
                S_PARITY: begin
                    if (dec_s) begin
                        par_err_d = (voted_s != parity_bit(9'(shift_q), PAR_MODE));
                    end else begin
                        par_err_d = par_err_q;
                    end
                    if (end_s) begin
                        state_d   = S_STOP;
                        bit_idx_d = '0;
                    end else begin
                        state_d = S_PARITY;
                    end
                end
                S_STOP: begin
                    // Leave mid-stop so the next start edge is never missed.
                    if (dec_s && !voted_s) begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end else if (dec_s && bit_idx_q == STOP_LAST) begin
                        if (par_err_q) begin
                            parity_err_d = 1'b1;
                        end else begin
                            push_s = 1'b1;
                        end
                        state_d = S_IDLE;
                    end else if (end_s) begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end else begin
                        state_d = S_STOP;
                    end
                end
                S_BREAK: begin
                    if (rx_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_BREAK;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
        busy_d = (state_d != S_IDLE);
    end

    // FSM state, datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            tick_cnt_q   <= '0;
            bit_idx_q    <= '0;
            vote_q       <= 2'b11;
            shift_q      <= '0;
            par_err_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_idx_q    <= bit_idx_d;
            vote_q       <= vote_d;
            shift_q      <= shift_d;
            par_err_q    <= par_err_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            busy_q       <= busy_d;
        end
    end

    uart_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data (shift_q),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .overrun   (overrun)
    );

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed testbench for uart_rx_param: three configurations share one serial
// driver; a scoreboard queue holds expected words, popped on each handshake.
module tb_uart_rx_param;

    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       baud_tick = 1'b1;
    logic       rx_line = 1'b1;
    logic       ready = 1'b1;
    logic [1:0] sel = 2'd0;

    logic       rx0, rx1, rx2;
    logic [7:0] d0_data, d1_data;
    logic [6:0] d2_data;
    logic       d0_valid, d0_ferr, d0_perr, d0_ovr, d0_busy;
    logic       d1_valid, d1_ferr, d1_perr, d1_ovr, d1_busy;
    logic       d2_valid, d2_ferr, d2_perr, d2_ovr, d2_busy;

    logic [8:0] mon_data;
    logic       mon_valid, mon_ferr, mon_perr, mon_ovr;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int n_hs = 0, n_ferr = 0, n_perr = 0, n_ovr = 0;

    always #5 clk = ~clk;

    assign rx0 = (sel == 2'd0) ? rx_line : 1'b1;
    assign rx1 = (sel == 2'd1) ? rx_line : 1'b1;
    assign rx2 = (sel == 2'd2) ? rx_line : 1'b1;

    uart_rx_param u_def (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .rx(rx0),
        .m_data(d0_data), .m_valid(d0_valid), .m_ready(ready),
        .frame_err(d0_ferr), .parity_err(d0_perr), .overrun(d0_ovr), .busy(d0_busy)
    );

    uart_rx_param #(.PARITY(2)) u_even (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .rx(rx1),
        .m_data(d1_data), .m_valid(d1_valid), .m_ready(ready),
        .frame_err(d1_ferr), .parity_err(d1_perr), .overrun(d1_ovr), .busy(d1_busy)
    );

    uart_rx_param #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_cfg (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .rx(rx2),
        .m_data(d2_data), .m_valid(d2_valid), .m_ready(ready),
        .frame_err(d2_ferr), .parity_err(d2_perr), .overrun(d2_ovr), .busy(d2_busy)
    );

    // Route the selected instance to the monitor.
    always_comb begin
        case (sel)
            2'd1: begin
                mon_data = {1'b0, d1_data}; mon_valid = d1_valid;
                mon_ferr = d1_ferr; mon_perr = d1_perr; mon_ovr = d1_ovr;
            end
            2'd2: begin
                mon_data = {2'b00, d2_data}; mon_valid = d2_valid;
                mon_ferr = d2_ferr; mon_perr = d2_perr; mon_ovr = d2_ovr;
            end
            default: begin
                mon_data = {1'b0, d0_data}; mon_valid = d0_valid;
                mon_ferr = d0_ferr; mon_perr = d0_perr; mon_ovr = d0_ovr;
            end
        endcase
    end

    // Output monitor: score each accepted word, count error pulses.
    always @(negedge clk) begin
        int exp_w;
        if (!reset) begin
            if (mon_valid && ready) begin
                n_hs++;
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_word observed=%0h expected=none", mon_data);
                end
                if (exp_q.size() != 0) begin
                    exp_w = exp_q.pop_front();
                    checks++;
                    assert (mon_data === exp_w[8:0]) else begin
                        errors++;
                        $error("FAIL word observed=%0h expected=%0h", mon_data, exp_w[8:0]);
                    end
                end
            end
            if (mon_ferr) n_ferr++;
            if (mon_perr) n_perr++;
            if (mon_ovr)  n_ovr++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic b, input int n);
        rx_line = b;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // par < 0 means no parity bit; stops = 0 sends start and data only.
    task automatic send_frame(input int data, input int nbits, input int par,
                              input int stops, input logic stop_val);
        drive(1'b0, OS);
        for (int i = 0; i < nbits; i++) drive(data[i], OS);
        if (par >= 0) drive(par[0], OS);
        for (int i = 0; i < stops; i++) drive(stop_val, OS);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    task automatic clear_counts();
        n_hs = 0; n_ferr = 0; n_perr = 0; n_ovr = 0;
    endtask

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_valid", d0_valid, 0);
        chk("rst_data", d0_data, 0);
        chk("rst_busy", d0_busy, 0);
        chk("rst_errs", {d0_ferr, d0_perr, d0_ovr}, 0);
        drive(1'b1, 2 * OS);

        // Back-to-back 8N1 frames
        sel = 2'd0; clear_counts();
        exp_q.push_back(32'h05); exp_q.push_back(32'h04); exp_q.push_back(32'h03);
        send_frame(8'h05, 8, -1, 1, 1'b1);
        send_frame(8'h04, 8, -1, 1, 1'b1);
        send_frame(8'h03, 8, -1, 1, 1'b1);
        drive(1'b1, 2 * OS);
        drain("b2b_drain");
        chk("b2b_hs", n_hs, 3);
        chk("b2b_errs", n_ferr + n_perr + n_ovr, 0);

        // Even parity: good then bad parity bit
        sel = 2'd1; clear_counts();
        exp_q.push_back(32'hA5);
        send_frame(8'hA5, 8, 0, 1, 1'b1);
        drive(1'b1, 2 * OS);
        drain("par_good_drain");
        send_frame(8'hA5, 8, 1, 1, 1'b1);
        drive(1'b1, 2 * OS);
        chk("par_bad_perr", n_perr, 1);
        chk("par_hs", n_hs, 1);

        // Stop bit low then held-low line (break)
        sel = 2'd0; clear_counts();
        send_frame(8'h3C, 8, -1, 0, 1'b1);
        drive(1'b0, 41 * OS);
        chk("brk_busy_low", d0_busy, 1);
        chk("brk_ferr", n_ferr, 1);
        drive(1'b1, 2 * OS);
        chk("brk_busy_idle", d0_busy, 0);
        exp_q.push_back(32'h11);
        send_frame(8'h11, 8, -1, 1, 1'b1);
        drive(1'b1, 2 * OS);
        drain("brk_next_drain");
        chk("brk_ferr_once", n_ferr, 1);

        // Glitches on idle line, then spike inside bit 3 of 0x00
        clear_counts();
        for (int g = 1; g <= 5; g++) begin
            drive(1'b0, g);
            drive(1'b1, 2 * OS);
        end
        chk("glitch_busy", d0_busy, 0);
        chk("glitch_out", n_hs + n_ferr, 0);
        exp_q.push_back(32'h00);
        drive(1'b0, OS);
        drive(1'b0, 3 * OS);
        drive(1'b0, 9);
        drive(1'b1, 1);
        drive(1'b0, OS - 10);
        drive(1'b0, 4 * OS);
        drive(1'b1, 2 * OS);
        drain("spike_drain");
        chk("spike_errs", n_ferr, 0);

        // Overrun with FIFO full and consumer stalled
        clear_counts();
        ready = 1'b0;
        for (int i = 1; i <= 4; i++) exp_q.push_back(i);
        for (int i = 1; i <= 5; i++) send_frame(i, 8, -1, 1, 1'b1);
        drive(1'b1, 2 * OS);
        chk("ovr_pulse", n_ovr, 1);
        chk("ovr_count", u_def.u_fifo.count_q, 4);
        chk("ovr_no_hs", n_hs, 0);
        // No ticks: a low pulse must not start a frame
        baud_tick = 1'b0;
        drive(1'b0, 50);
        drive(1'b1, 10);
        baud_tick = 1'b1;
        drive(1'b1, 4);
        chk("notick_busy", d0_busy, 0);
        ready = 1'b1;
        drain("ovr_drain");
        chk("ovr_hs", n_hs, 4);

        // 7 data bits, odd parity, 2 stop bits; reset mid-frame
        sel = 2'd2; clear_counts();
        ready = 1'b0;
        send_frame(7'h55, 7, 1, 2, 1'b1);
        drive(1'b1, OS);
        chk("cfg_held_valid", d2_valid, 1);
        chk("cfg_held_data", d2_data, 7'h55);
        drive(1'b0, OS);
        for (int i = 0; i < 4; i++) drive(1'b0, OS);
        drive(1'b1, 8);
        reset = 1'b1;
        rx_line = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        chk("cfg_rst_valid", d2_valid, 0);
        chk("cfg_rst_data", d2_data, 0);
        chk("cfg_rst_busy", d2_busy, 0);
        chk("cfg_rst_errs", {d2_ferr, d2_perr, d2_ovr}, 0);
        drive(1'b1, 2 * OS);
        ready = 1'b1;
        exp_q.push_back(32'h2A);
        send_frame(7'h2A, 7, 0, 2, 1'b1);
        drive(1'b1, 2 * OS);
        drain("cfg_drain");
        chk("cfg_hs", n_hs, 1);
        chk("cfg_errs", n_ferr + n_perr + n_ovr, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
